// File: rtl/sos_measure_scheduler.sv
// -----------------------------------------------------------------------------
// sos_measure_scheduler
//
// Purpose:
//   Sweeps NUM_CH speaker channels that share one speed-of-sound distance
//   calculator and impulse generator. For every channel it routes the speaker,
//   lets the analog path settle, fires the calculator trigger and waits for a
//   delay reading. SAMPLES valid readings are summed and reported as a
//   truncated average. A reading that does not arrive within TIMEOUT_CYCLES is
//   a miss. After MAX_RETRIES misses on one channel, that channel is reported
//   as failed and the sweep moves on to the next channel.
//
// Ports:
//   clk_in               system clock
//   rst_in               asynchronous active-high reset
//   start_in             single-cycle pulse, starts a sweep at channel 0 (idle only)
//   abort_in             level, drops any sweep in progress back to idle
//   calc_trigger_out     one-cycle trigger pulse to the distance calculator
//   calc_delay_in        delay reading from the calculator (24 kHz samples)
//   calc_delay_valid_in  calculator valid level (held high until next trigger)
//   ch_sel_out           speaker / channel route select
//   busy_out             high whenever the scheduler is not idle
//   result_ch_out        channel of the most recent result
//   result_delay_out     averaged delay, 12'hFFF when the channel failed
//   result_fail_out      channel exhausted its retries
//   result_valid_out     one-cycle pulse per channel result
//   sweep_done_out       one-cycle pulse after the last channel's result
// -----------------------------------------------------------------------------
module sos_measure_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int SAMPLES        = 4,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 12_000_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic                      abort_in,
    output logic                      calc_trigger_out,
    input  logic [11:0]               calc_delay_in,
    input  logic                      calc_delay_valid_in,
    output logic [$clog2(NUM_CH)-1:0] ch_sel_out,
    output logic                      busy_out,
    output logic [$clog2(NUM_CH)-1:0] result_ch_out,
    output logic [11:0]               result_delay_out,
    output logic                      result_fail_out,
    output logic                      result_valid_out,
    output logic                      sweep_done_out
);

    // -------------------------------------------------------------------------
    // Derived widths and terminal-count constants
    // -------------------------------------------------------------------------
    localparam int CH_W      = $clog2(NUM_CH);
    localparam int SMP_SHIFT = $clog2(SAMPLES);
    // SAMPLES readings of 12 bits each can never overflow this width.
    localparam int ACC_W     = 12 + SMP_SHIFT;
    // Counters must be able to hold their terminal value (SAMPLES, MAX_RETRIES).
    localparam int SC_W      = $clog2(SAMPLES + 1);
    localparam int RC_W      = $clog2(MAX_RETRIES + 1);
    // One timer serves both SETTLE and WAIT; size it for the longer of the two.
    localparam int TMR_MAX   = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W     = $clog2(TMR_MAX);

    localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CH - 1);
    localparam logic [SC_W-1:0]  SAMPLES_LAST = SC_W'(SAMPLES - 1);
    localparam logic [RC_W-1:0]  RETRY_LAST   = RC_W'(MAX_RETRIES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0]      FAIL_DELAY   = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_TRIGGER,
        ST_WAIT,
        ST_REPORT,
        ST_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_reg;
    logic [CH_W-1:0]   ch_reg;
    logic [SC_W-1:0]   sample_cnt_reg;
    logic [RC_W-1:0]   retry_cnt_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic              valid_q_reg;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    // The calculator's valid is a level held until the next trigger, so only a
    // fresh rising edge marks a new reading.
    logic              sample_edge;
    logic [ACC_W-1:0]  acc_sum;
    logic [11:0]       acc_avg;

    assign sample_edge = calc_delay_valid_in & ~valid_q_reg;
    assign acc_sum     = acc_reg + ACC_W'(calc_delay_in);
    // Dropping the low SMP_SHIFT bits is the truncating divide by SAMPLES.
    assign acc_avg     = acc_sum[ACC_W-1:SMP_SHIFT];

    // The route select is the channel counter itself: it only changes in
    // REPORT (or on start/reset), so it is stable through SETTLE..REPORT.
    assign ch_sel_out  = ch_reg;

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg        <= ST_IDLE;
            ch_reg           <= '0;
            sample_cnt_reg   <= '0;
            retry_cnt_reg    <= '0;
            acc_reg          <= '0;
            timer_reg        <= '0;
            valid_q_reg      <= 1'b0;
            calc_trigger_out <= 1'b0;
            busy_out         <= 1'b0;
            result_ch_out    <= '0;
            result_delay_out <= '0;
            result_fail_out  <= 1'b0;
            result_valid_out <= 1'b0;
            sweep_done_out   <= 1'b0;
        end else begin
            valid_q_reg <= calc_delay_valid_in;

            // Pulse outputs are asserted only on the transition into the
            // state they belong to, so they last exactly that state's cycle.
            calc_trigger_out <= 1'b0;
            result_valid_out <= 1'b0;
            sweep_done_out   <= 1'b0;

            if (abort_in && (state_reg != ST_IDLE)) begin
                // Abort beats every other transition; nothing is reported.
                state_reg <= ST_IDLE;
                busy_out  <= 1'b0;
                timer_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        // abort_in on the same cycle cancels the start.
                        if (start_in && !abort_in) begin
                            ch_reg         <= '0;
                            sample_cnt_reg <= '0;
                            retry_cnt_reg  <= '0;
                            acc_reg        <= '0;
                            timer_reg      <= '0;
                            busy_out       <= 1'b1;
                            state_reg      <= ST_SETTLE;
                        end
                    end

                    ST_SETTLE: begin
                        if (timer_reg == SETTLE_LAST) begin
                            timer_reg        <= '0;
                            calc_trigger_out <= 1'b1;
                            state_reg        <= ST_TRIGGER;
                        end else begin
                            timer_reg <= timer_reg + TMR_W'(1);
                        end
                    end

                    ST_TRIGGER: begin
                        timer_reg <= '0;
                        state_reg <= ST_WAIT;
                    end

                    ST_WAIT: begin
                        // The edge check comes first so a reading that lands
                        // on the final timeout cycle is kept, not missed.
                        if (sample_edge) begin
                            acc_reg        <= acc_sum;
                            sample_cnt_reg <= sample_cnt_reg + SC_W'(1);
                            timer_reg      <= '0;
                            if (sample_cnt_reg == SAMPLES_LAST) begin
                                result_valid_out <= 1'b1;
                                result_ch_out    <= ch_reg;
                                result_delay_out <= acc_avg;
                                result_fail_out  <= 1'b0;
                                state_reg        <= ST_REPORT;
                            end else begin
                                state_reg <= ST_SETTLE;
                            end
                        end else if (timer_reg == TIMEOUT_LAST) begin
                            // Miss: retries are per channel and already
                            // accumulated samples are kept for the resample.
                            retry_cnt_reg <= retry_cnt_reg + RC_W'(1);
                            timer_reg     <= '0;
                            if (retry_cnt_reg == RETRY_LAST) begin
                                result_valid_out <= 1'b1;
                                result_ch_out    <= ch_reg;
                                result_delay_out <= FAIL_DELAY;
                                result_fail_out  <= 1'b1;
                                state_reg        <= ST_REPORT;
                            end else begin
                                state_reg <= ST_SETTLE;
                            end
                        end else begin
                            timer_reg <= timer_reg + TMR_W'(1);
                        end
                    end

                    ST_REPORT: begin
                        if (ch_reg == LAST_CH) begin
                            sweep_done_out <= 1'b1;
                            state_reg      <= ST_DONE;
                        end else begin
                            ch_reg         <= ch_reg + CH_W'(1);
                            sample_cnt_reg <= '0;
                            retry_cnt_reg  <= '0;
                            acc_reg        <= '0;
                            timer_reg      <= '0;
                            state_reg      <= ST_SETTLE;
                        end
                    end

                    ST_DONE: begin
                        busy_out  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end

                    default: begin
                        busy_out  <= 1'b0;
                        timer_reg <= '0;
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
